bsg_link_delay_line_programmer: RTL



---
 rtl/bsg_link_delay_line_programmer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bsg_link_delay_line_programmer.sv
// ============================================================================
// Module   : bsg_link_delay_line_programmer
// Purpose  : Shifts a 36-bit delay-select vector out over four bsg_tag client
//            streams (MSB first, in parallel), then commits it.
// Option   : BSG_LINK_DELAY_PROG_SKIP_UNCHANGED_EN - only reprogram clients
//            whose field changed since the last commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_link_delay_line_programmer #(
    parameter int width_p     = 18,
    parameter int sel_width_p = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             v_i,
    input  logic [width_p*sel_width_p-1:0]   sel_i,
    output logic                             ready_o,
    output logic [11:0]                      tag_lines_o,
    output logic                             done_o
);

    // Per-client data width and LSB position within the select vector.
    localparam int c_CLI_W   [4] = '{12, 12, 10, 2};
    localparam int c_CLI_LSB [4] = '{0, 12, 24, 34};
    localparam logic [3:0] c_LAST_CNT = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [35:0] r_sel;
    logic [3:0]  r_active;
    logic [11:0] r_tag;
    logic [11:0] w_tag_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_load;
    logic [3:0]  w_hs_active;

    function automatic logic [11:0] f_shift_tag(input logic [35:0] vec,
                                                input logic [3:0]  cnt,
                                                input logic [3:0]  act);
        logic [11:0] tag;
        int          idx;
        logic        b;
        tag = '0;
        for (int k = 0; k < 4; k++) begin
            if (act[k] && (int'(cnt) < c_CLI_W[k])) begin
                idx = c_CLI_LSB[k] + c_CLI_W[k] - 1 - int'(cnt);
                b   = vec[idx[5:0]];
                tag = tag | (12'({1'b1, b, 1'b1}) << (3 * k));
            end
        end
        return tag;
    endfunction

    function automatic logic [11:0] f_commit_tag(input logic [3:0] act);
        logic [11:0] tag;
        tag = '0;
        for (int k = 0; k < 4; k++) begin
            if (act[k]) begin
                tag = tag | (12'(3'b011) << (3 * k));
            end
        end
        return tag;
    endfunction

`ifdef BSG_LINK_DELAY_PROG_SKIP_UNCHANGED_EN
    logic [35:0] r_shadow;
    logic        r_shadow_v;

    // Shadow of the last vector that actually reached a commit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_shadow   <= '0;
            r_shadow_v <= 1'b0;
        end else if (r_state == S_COMMIT) begin
            r_shadow   <= r_sel;
            r_shadow_v <= 1'b1;
        end
    end

    always_comb begin
        w_hs_active    = 4'hF;
        if (r_shadow_v) begin
            w_hs_active[0] = (sel_i[11:0]  != r_shadow[11:0]);
            w_hs_active[1] = (sel_i[23:12] != r_shadow[23:12]);
            w_hs_active[2] = (sel_i[33:24] != r_shadow[33:24]);
            w_hs_active[3] = (sel_i[35:34] != r_shadow[35:34]);
        end
    end
`else
    assign w_hs_active = 4'hF;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tag_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (v_i) begin
                    w_load = 1'b1;
                    if (w_hs_active != 4'h0) begin
                        w_state_nxt = S_SHIFT;
                        w_cnt_nxt   = 4'd0;
                        w_tag_nxt   = f_shift_tag(sel_i, 4'd0, w_hs_active);
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_LAST_CNT) begin
                    w_state_nxt = S_COMMIT;
                    w_tag_nxt   = f_commit_tag(r_active);
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                    w_tag_nxt   = f_shift_tag(r_sel, r_cnt + 4'd1, r_active);
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_active <= '0;
            r_tag    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tag   <= w_tag_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_sel    <= sel_i;
                r_active <= w_hs_active;
            end
        end
    end

    assign ready_o     = (r_state == S_IDLE);
    assign tag_lines_o = r_tag;
    assign done_o      = r_done;

endmodule

`default_nettype wire
